// File: rtl/mult16u_dot_accum.sv
// Dot-product accumulator: sums unsigned product beats of a vector with saturation,
// counts the beats and presents one registered result per vector.
module mult16u_dot_accum #(
   parameter int PROD_W = 32,
   parameter int ACC_W  = 40
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [PROD_W-1:0] in_product,
   input  logic              in_valid,
   input  logic              in_last,
   output logic              in_ready,
   output logic [ACC_W-1:0]  out_sum,
   output logic [15:0]       out_count,
   output logic              out_ovf,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [1:0]        dbg_state
);

   generate
      if (ACC_W < PROD_W) begin : g_bad_width
         $error("mult16u_dot_accum: ACC_W must be >= PROD_W");
      end
   endgenerate

   // Handshakes: a beat moves when in_valid && in_ready, a result moves when
   // out_valid && out_ready; both ready/valid outputs are registered and never
   // depend on the same-cycle partner signal.
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_HOLD  = 2'd2
   } state_t;

   state_t             state_q;
   logic [ACC_W-1:0]   acc_q;
   logic [15:0]        cnt_q;
   logic               ovf_q;
   logic               in_ready_q;
   logic [ACC_W-1:0]   out_sum_q;
   logic [15:0]        out_count_q;
   logic               out_ovf_q;
   logic               out_valid_q;

   logic               xfer;
   logic               first_beat;
   logic [ACC_W-1:0]   prod_ext;
   logic [ACC_W-1:0]   acc_base;
   logic [ACC_W:0]     sum_wide;
   logic               sat;
   logic [ACC_W-1:0]   acc_d;
   logic [15:0]        cnt_d;
   logic               ovf_d;

   assign xfer       = in_valid & in_ready_q;
   assign first_beat = (state_q != S_ACCUM);
   assign prod_ext   = ACC_W'(in_product);

   // The first beat of a vector starts from zero, so nothing leaks between vectors.
   always_comb begin
      acc_base = first_beat ? '0 : acc_q;
      sum_wide = {1'b0, acc_base} + {1'b0, prod_ext};
      sat      = sum_wide[ACC_W];
      acc_d    = sat ? '1 : sum_wide[ACC_W-1:0];
      ovf_d    = (first_beat ? 1'b0 : ovf_q) | sat;
      if (first_beat)
         cnt_d = 16'd1;
      else if (cnt_q == 16'hFFFF)
         cnt_d = cnt_q;
      else
         cnt_d = cnt_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         acc_q       <= '0;
         cnt_q       <= '0;
         ovf_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         out_sum_q   <= '0;
         out_count_q <= '0;
         out_ovf_q   <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE, S_ACCUM: begin
               if (xfer) begin
                  if (in_last) begin
                     out_sum_q   <= acc_d;
                     out_count_q <= cnt_d;
                     out_ovf_q   <= ovf_d;
                     out_valid_q <= 1'b1;
                     in_ready_q  <= 1'b0;
                     acc_q       <= '0;
                     cnt_q       <= '0;
                     ovf_q       <= 1'b0;
                     state_q     <= S_HOLD;
                  end else begin
                     acc_q   <= acc_d;
                     cnt_q   <= cnt_d;
                     ovf_q   <= ovf_d;
                     state_q <= S_ACCUM;
                  end
               end
            end
            S_HOLD: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= S_IDLE;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               state_q     <= S_IDLE;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_sum   = out_sum_q;
   assign out_count = out_count_q;
   assign out_ovf   = out_ovf_q;
   assign out_valid = out_valid_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_mult16u_dot_accum.sv
// Bench for mult16u_dot_accum: directed scenarios plus randomized vectors checked
// against a plain-arithmetic saturating dot-product model.
module tb_mult16u_dot_accum;

   localparam int PROD_W = 32;
   localparam int ACC_W  = 40;
   localparam int ACC32  = 32;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [PROD_W-1:0] in_product;
   logic              in_valid;
   logic              in_last;
   logic              in_ready;
   logic [ACC_W-1:0]  out_sum;
   logic [15:0]       out_count;
   logic              out_ovf;
   logic              out_valid;
   logic              out_ready;
   logic [1:0]        dbg_state;

   logic [PROD_W-1:0] p32_product;
   logic              p32_valid;
   logic              p32_last;
   logic              p32_in_ready;
   logic [ACC32-1:0]  p32_sum;
   logic [15:0]       p32_count;
   logic              p32_ovf;
   logic              p32_out_valid;
   logic              p32_out_ready;
   logic [1:0]        p32_dbg_state;

   int total = 0;
   int bad   = 0;
   logic [ACC_W-1:0] exp_q[$];

   mult16u_dot_accum #(.PROD_W(PROD_W), .ACC_W(ACC_W)) dut (
      .clk(clk), .rst_n(rst_n), .in_product(in_product), .in_valid(in_valid),
      .in_last(in_last), .in_ready(in_ready), .out_sum(out_sum), .out_count(out_count),
      .out_ovf(out_ovf), .out_valid(out_valid), .out_ready(out_ready), .dbg_state(dbg_state)
   );

   mult16u_dot_accum #(.PROD_W(PROD_W), .ACC_W(ACC32)) dut32 (
      .clk(clk), .rst_n(rst_n), .in_product(p32_product), .in_valid(p32_valid),
      .in_last(p32_last), .in_ready(p32_in_ready), .out_sum(p32_sum), .out_count(p32_count),
      .out_ovf(p32_ovf), .out_valid(p32_out_valid), .out_ready(p32_out_ready),
      .dbg_state(p32_dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference model: saturating sum of a vector of beats, count capped at 65535.
   function automatic void model(input logic [31:0] beats[$], input int accw,
                                 output logic [63:0] s, output logic [15:0] c,
                                 output bit ovf);
      logic [63:0] mx;
      mx  = (64'd1 << accw) - 64'd1;
      s   = 64'd0;
      c   = 16'd0;
      ovf = 1'b0;
      foreach (beats[i]) begin
         if (s + 64'(beats[i]) > mx) begin
            s   = mx;
            ovf = 1'b1;
         end else begin
            s = s + 64'(beats[i]);
         end
         if (c != 16'hFFFF) c = c + 16'd1;
      end
   endfunction

   // driver tasks
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_beat(input logic [31:0] p, input logic last);
      int n;
      in_product = p;
      in_last    = last;
      in_valid   = 1'b1;
      n = 0;
      while (in_ready !== 1'b1 && n < 100) begin
         step();
         n++;
      end
      total++;
      if (n >= 100) begin
         bad++;
         $display("FAIL drive_timeout in_ready=%b required=1", in_ready);
      end
      step();
      in_valid   = 1'b0;
      in_last    = 1'b0;
      in_product = $urandom;
   endtask

   task automatic idle_gap();
      repeat ($urandom_range(0, 2)) begin
         in_product = $urandom;
         step();
      end
   endtask

   task automatic test_reset();
      rst_n      = 1'b0;
      in_valid   = 1'b1;
      in_last    = 1'b1;
      in_product = 32'hDEAD_BEEF;
      out_ready  = 1'b0;
      p32_valid = 1'b0; p32_last = 1'b0; p32_product = '0; p32_out_ready = 1'b1;
      repeat (3) step();
      in_valid = 1'b0;
      in_last  = 1'b0;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      total++; if (out_sum !== '0) begin bad++; $display("FAIL reset_out_sum got=%0h exp=0", out_sum); end
      total++; if (out_count !== 16'd0) begin bad++; $display("FAIL reset_out_count got=%0d exp=0", out_count); end
      total++; if (out_ovf !== 1'b0) begin bad++; $display("FAIL reset_out_ovf got=%b exp=0", out_ovf); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
      total++; if (p32_in_ready !== 1'b1 || p32_dbg_state !== 2'd0) begin bad++; $display("FAIL reset_dut32 in_ready=%b state=%0d exp=1/0", p32_in_ready, p32_dbg_state); end
      rst_n = 1'b1;
      out_ready = 1'b1;
      repeat (2) step();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL idle_out_ready got=%b exp=0", out_valid); end
   endtask

   task automatic test_basic();
      out_ready = 1'b1;
      drive_beat(32'd3, 1'b0);
      drive_beat(32'd5, 1'b0);
      drive_beat(32'd7, 1'b1);
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b exp=1", out_valid); end
      total++; if (out_sum !== 40'd15) begin bad++; $display("FAIL basic_sum got=%0d exp=15", out_sum); end
      total++; if (out_count !== 16'd3) begin bad++; $display("FAIL basic_count got=%0d exp=3", out_count); end
      total++; if (out_ovf !== 1'b0) begin bad++; $display("FAIL basic_ovf got=%b exp=0", out_ovf); end
      total++; if (in_ready !== 1'b0 || dbg_state !== 2'd2) begin bad++; $display("FAIL basic_hold in_ready=%b state=%0d exp=0/2", in_ready, dbg_state); end
      step();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_pulse got=%b exp=0", out_valid); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL basic_ready_back got=%b exp=1", in_ready); end
   endtask

   task automatic test_no_carry();
      out_ready = 1'b1;
      drive_beat(32'hFFFE_0001, 1'b1);
      total++; if (out_sum !== 40'hFF_FE00_01 >> 0 && out_sum !== 40'h00_FFFE_0001) begin bad++; $display("FAIL single_sum got=%0h exp=fffe0001", out_sum); end
      total++; if (out_count !== 16'd1 || out_valid !== 1'b1) begin bad++; $display("FAIL single_count got=%0d valid=%b exp=1/1", out_count, out_valid); end
      step();
      drive_beat(32'd1, 1'b0);
      drive_beat(32'd2, 1'b1);
      total++; if (out_sum !== 40'd3 || out_count !== 16'd2) begin bad++; $display("FAIL carry_sum got=%0h/%0d exp=3/2", out_sum, out_count); end
      step();
   endtask

   task automatic test_sat32();
      total++; if (p32_in_ready !== 1'b1) begin bad++; $display("FAIL sat32_ready got=%b exp=1", p32_in_ready); end
      p32_valid = 1'b1; p32_product = 32'hFFFF_FFFF; p32_last = 1'b0;
      step();
      p32_product = 32'd1; p32_last = 1'b1;
      step();
      p32_valid = 1'b0; p32_last = 1'b0;
      total++; if (p32_out_valid !== 1'b1) begin bad++; $display("FAIL sat32_valid got=%b exp=1", p32_out_valid); end
      total++; if (p32_sum !== 32'hFFFF_FFFF) begin bad++; $display("FAIL sat32_sum got=%0h exp=ffffffff", p32_sum); end
      total++; if (p32_ovf !== 1'b1 || p32_count !== 16'd2) begin bad++; $display("FAIL sat32_ovf got=%b/%0d exp=1/2", p32_ovf, p32_count); end
      step();
      p32_valid = 1'b1; p32_product = 32'd5; p32_last = 1'b1;
      step();
      p32_valid = 1'b0; p32_last = 1'b0;
      total++; if (p32_sum !== 32'd5 || p32_ovf !== 1'b0) begin bad++; $display("FAIL sat32_clear got=%0h/%b exp=5/0", p32_sum, p32_ovf); end
      step();
   endtask

   task automatic test_backpressure();
      logic [31:0] a, b, c;
      logic [63:0] es;
      a = $urandom; b = $urandom; c = $urandom;
      es = 64'(a) + 64'(b);
      out_ready = 1'b0;
      drive_beat(a, 1'b0);
      drive_beat(b, 1'b1);
      in_product = c; in_last = 1'b1; in_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         total++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold%0d in_ready=%b valid=%b exp=0/1", k, in_ready, out_valid); end
         total++; if (out_sum !== es[ACC_W-1:0] || out_count !== 16'd2 || out_ovf !== 1'b0) begin bad++; $display("FAIL bp_stable%0d got=%0h/%0d/%b exp=%0h/2/0", k, out_sum, out_count, out_ovf, es); end
         step();
      end
      out_ready = 1'b1;
      step();
      total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL bp_release valid=%b in_ready=%b exp=0/1", out_valid, in_ready); end
      step();
      in_valid = 1'b0; in_last = 1'b0;
      total++; if (out_valid !== 1'b1 || out_sum !== 40'(c) || out_count !== 16'd1) begin bad++; $display("FAIL bp_held_beat got=%b/%0h/%0d exp=1/%0h/1", out_valid, out_sum, out_count, c); end
      step();
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b1;
      drive_beat(32'd100, 1'b0);
      drive_beat(32'd200, 1'b0);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_no_valid%0d got=%b exp=0", k, out_valid); end
         step();
      end
      drive_beat(32'd10, 1'b0);
      drive_beat(32'd20, 1'b1);
      total++; if (out_sum !== 40'd30 || out_count !== 16'd2) begin bad++; $display("FAIL rstmid_sum got=%0d/%0d exp=30/2", out_sum, out_count); end
      step();
      out_ready = 1'b0;
      drive_beat(32'd7, 1'b1);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      total++; if (out_valid !== 1'b0 || out_sum !== '0) begin bad++; $display("FAIL rsthold_drop got=%b/%0h exp=0/0", out_valid, out_sum); end
      out_ready = 1'b1;
      step();
   endtask

   task automatic test_back_to_back();
      logic [31:0] p;
      out_ready = 1'b1;
      in_valid = 1'b1;
      in_last  = 1'b1;
      for (int k = 0; k < 8; k++) begin
         p = $urandom;
         in_product = p;
         total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready%0d got=%b exp=1", k, in_ready); end
         step();
         in_product = $urandom;
         total++; if (out_valid !== 1'b1 || out_sum !== 40'(p) || out_count !== 16'd1) begin bad++; $display("FAIL b2b_result%0d got=%b/%0h/%0d exp=1/%0h/1", k, out_valid, out_sum, out_count, p); end
         total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_hold%0d got=%b exp=0", k, in_ready); end
         step();
         total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_gap%0d got=%b exp=0", k, out_valid); end
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic test_random();
      logic [31:0] beats[$];
      logic [63:0] es;
      logic [15:0] ec;
      bit          eo;
      logic [ACC_W-1:0] exp_sum;
      int len;
      for (int v = 0; v < 25; v++) begin
         beats.delete();
         len = $urandom_range(1, 6);
         for (int i = 0; i < len; i++)
            beats.push_back(($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom);
         model(beats, ACC_W, es, ec, eo);
         exp_q.push_back(es[ACC_W-1:0]);
         for (int i = 0; i < len; i++) begin
            out_ready = (i == len - 1) ? 1'b0 : 1'($urandom_range(0, 1));
            idle_gap();
            drive_beat(beats[i], (i == len - 1));
         end
         exp_sum = exp_q.pop_front();
         total++; if (out_valid !== 1'b1 || out_sum !== exp_sum) begin bad++; $display("FAIL rand%0d_sum got=%b/%0h exp=1/%0h", v, out_valid, out_sum, exp_sum); end
         total++; if (out_count !== ec || out_ovf !== eo) begin bad++; $display("FAIL rand%0d_cnt got=%0d/%b exp=%0d/%b", v, out_count, out_ovf, ec, eo); end
         repeat ($urandom_range(0, 3)) begin
            step();
            total++; if (out_valid !== 1'b1 || out_sum !== exp_sum) begin bad++; $display("FAIL rand%0d_stable got=%b/%0h exp=1/%0h", v, out_valid, out_sum, exp_sum); end
         end
         out_ready = 1'b1;
         step();
         total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rand%0d_pop got=%b exp=0", v, out_valid); end
      end
   endtask

   task automatic test_count_sat();
      out_ready  = 1'b1;
      in_valid   = 1'b1;
      in_last    = 1'b0;
      in_product = 32'hFFFF_FFFF;
      repeat (65536) step();
      total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL long_stream in_ready=%b valid=%b exp=1/0", in_ready, out_valid); end
      in_last = 1'b1;
      step();
      in_valid = 1'b0;
      in_last  = 1'b0;
      total++; if (out_count !== 16'hFFFF) begin bad++; $display("FAIL count_sat got=%0d exp=65535", out_count); end
      total++; if (out_sum !== {ACC_W{1'b1}} || out_ovf !== 1'b1) begin bad++; $display("FAIL sum_sat40 got=%0h/%b exp=ffffffffff/1", out_sum, out_ovf); end
      step();
      drive_beat(32'd9, 1'b1);
      total++; if (out_sum !== 40'd9 || out_ovf !== 1'b0 || out_count !== 16'd1) begin bad++; $display("FAIL sat_clear got=%0h/%b/%0d exp=9/0/1", out_sum, out_ovf, out_count); end
      step();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_no_carry();
      test_sat32();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      test_random();
      test_count_sat();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mult16u_dot_accum.md
MULT16U_DOT_ACCUM -- requirements
Module: mult16u_dot_accum

Interface
REQ-001 Parameter PROD_W, default 32: width of the unsigned product input (16x16 multiplier output).
REQ-002 Parameter ACC_W, default 40: accumulator and result width; ACC_W >= PROD_W SHALL be enforced at elaboration.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_product  input  PROD_W  unsigned product beat from the upstream registered multiplier wrapper.
REQ-006 in_valid  input  1  in_product/in_last are valid this cycle.
REQ-007 in_last  input  1  current beat is the final beat of a dot-product vector.
REQ-008 in_ready  output  1  block can accept a beat this cycle.
REQ-009 out_sum  output  ACC_W  completed dot-product sum.
REQ-010 out_count  output  16  number of beats in the completed vector.
REQ-011 out_ovf  output  1  sum saturated during the vector.
REQ-012 out_valid  output  1  out_sum/out_count/out_ovf are valid.
REQ-013 out_ready  input  1  downstream accepts the result this cycle.

Function
REQ-014 The block SHALL implement three states: IDLE (no vector in progress), ACCUM (at least one beat of the vector accepted), HOLD (result pending).
REQ-015 in_ready SHALL be 1 in IDLE and ACCUM, and 0 in HOLD; it SHALL not depend combinationally on in_valid.
REQ-016 An input transfer SHALL occur only on a cycle with in_valid=1 and in_ready=1; in_product is ignored otherwise.
REQ-017 On a transfer in IDLE, next acc = zero-extended in_product; in ACCUM, next acc = acc + zero-extended in_product.
REQ-018 Addition SHALL saturate at 2^ACC_W-1; any saturating add SHALL set a sticky ovf flag for the current vector.
REQ-019 The beat counter SHALL load 1 on the first beat, increment on every later beat, and saturate at 65535.
REQ-020 Transfer without in_last: IDLE->ACCUM or ACCUM->ACCUM.
REQ-021 Transfer with in_last (including the first beat): the final sum, count and ovf SHALL be loaded into the output registers, out_valid SHALL be 1 on the next cycle, and the state SHALL go to HOLD.
REQ-022 Latency from the last-beat transfer edge to out_valid=1 SHALL be exactly one cycle.
REQ-023 In HOLD, out_sum/out_count/out_ovf SHALL remain stable until the handshake completes.
REQ-024 A cycle with out_valid=1 and out_ready=1 SHALL clear out_valid and return the state to IDLE on the next edge; in_ready is 1 from that next cycle.
REQ-025 There SHALL be no same-cycle bypass: the minimum gap between consecutive results is two cycles.
REQ-026 out_ready while out_valid=0 SHALL have no effect.
REQ-027 in_valid held high during HOLD SHALL not be consumed; the beat SHALL be accepted in the first cycle in_ready returns to 1.
REQ-028 Accumulator, counter and ovf SHALL reset to their IDLE meaning at the start of each vector; nothing carries over between vectors.

Reset
REQ-029 While rst_n=0 at a clock edge: state=IDLE, out_valid=0, out_sum=0, out_count=0, out_ovf=0, accumulator=0, counter=0, and in_ready=1 from the following cycle.
REQ-030 Reset asserted mid-vector or in HOLD SHALL discard the partial sum or pending result without emitting it.

Verification
REQ-031 Beats 3, 5, 7 (last on 7), out_ready=1 -> one cycle after the last beat: out_sum=15, out_count=3, out_ovf=0, out_valid for exactly 1 cycle.
REQ-032 Single beat 0xFFFE0001 with in_last -> out_sum=0xFFFE0001, out_count=1; the following vector of beats 1, 2 gives out_sum=3 (no carry-over).
REQ-033 ACC_W=32, beats 0xFFFFFFFF then 1 (last) -> out_sum=0xFFFFFFFF, out_ovf=1.
REQ-034 Result pending, out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, outputs stable throughout; on the out_ready=1 cycle the result is taken; in_ready=1 on the next cycle and the held beat is accepted.
REQ-035 rst_n pulsed low after 2 of 4 beats -> no out_valid; the next vector of beats 10, 20 (last) gives out_sum=30, out_count=2.
REQ-036 Back-to-back vectors of one beat each with out_ready=1 -> out_valid pulses spaced two cycles apart; every sum equals its beat.
